// File: rtl/accel_ctrl_pkg.sv
// Shared definitions for accelerator control blocks: join FSM encoding and
// the legal range of done-pulse sources a join can accept.
package accel_ctrl_pkg;

   localparam int unsigned NUM_SRC_MIN = 1;
   localparam int unsigned NUM_SRC_MAX = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_FIRE  = 2'd2
   } join_state_e;

endpackage

// File: rtl/gen_done_join_done_sticky.sv
// One sticky done flag: loaded at window start from the coinciding pulse,
// accumulates masked pulses while the window is open, cleared otherwise.
module done_sticky (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic load_en,
   input  logic active,
   input  logic active_en,
   input  logic done,
   output logic sticky
);

   logic sticky_q;
   logic sticky_d;

   always_comb begin
      sticky_d = 1'b0;
      if (load) begin
         sticky_d = load_en & done;
      end else if (active) begin
         sticky_d = sticky_q | (active_en & done);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign sticky = sticky_q;

endmodule

// File: rtl/gen_done_join.sv
// Joins per-source done pulses of a tile into a single join_done pulse,
// with an optional window timeout and a wrapping completed-tile counter.
module gen_done_join
   import accel_ctrl_pkg::*;
#(
   parameter int NUM_SRC = 2,
   parameter int TO_W    = 20,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tile_start,
   input  logic [NUM_SRC-1:0] src_mask,
   input  logic [NUM_SRC-1:0] src_done,
   input  logic [TO_W-1:0]    timeout_cyc,
   output logic               join_done,
   output logic               join_timeout,
   output logic [NUM_SRC-1:0] pending,
   output logic               busy,
   output logic [CNT_W-1:0]   tile_cnt
);

   if ((NUM_SRC < NUM_SRC_MIN) || (NUM_SRC > NUM_SRC_MAX)) begin : g_bad_num_src
      $error("gen_done_join: NUM_SRC out of range");
   end

   join_state_e        state_q, state_d;
   logic [NUM_SRC-1:0] mask_q, mask_d;
   logic [TO_W-1:0]    to_lim_q, to_lim_d;
   logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
   logic [CNT_W-1:0]   tile_cnt_q, tile_cnt_d;
   logic               join_timeout_q, join_timeout_d;

   logic [NUM_SRC-1:0] sticky;
   logic [TO_W-1:0]    to_cnt_inc;
   logic               armed;
   logic               start_join;
   logic               armed_join;
   logic               to_hit;

   assign armed = (state_q == ST_ARMED);

   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_sticky
      done_sticky u_sticky (
         .clk      (clk),
         .rst      (rst),
         .load     (tile_start),
         .load_en  (src_mask[gi]),
         .active   (armed),
         .active_en(mask_q[gi]),
         .done     (src_done[gi]),
         .sticky   (sticky[gi])
      );
   end

   // A pulse coinciding with the start, or the last pulse of a window,
   // completes the join in its own cycle.
   assign start_join = &(~src_mask | src_done);
   assign armed_join = &(~mask_q | sticky | src_done);
   assign to_cnt_inc = to_cnt_q + TO_W'(1);
   assign to_hit     = (to_lim_q != '0) && (to_cnt_inc == to_lim_q);

   always_comb begin
      state_d        = state_q;
      mask_d         = mask_q;
      to_lim_d       = to_lim_q;
      to_cnt_d       = to_cnt_q;
      tile_cnt_d     = tile_cnt_q;
      join_timeout_d = 1'b0;

      if (tile_start) begin
         mask_d   = src_mask;
         to_lim_d = timeout_cyc;
         to_cnt_d = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (tile_start) begin
               state_d = start_join ? ST_FIRE : ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (tile_start) begin
               state_d = start_join ? ST_FIRE : ST_ARMED;
            end else if (armed_join) begin
               state_d = ST_FIRE;
            end else begin
               to_cnt_d = to_cnt_inc;
               if (to_hit) begin
                  state_d        = ST_IDLE;
                  join_timeout_d = 1'b1;
               end
            end
         end
         ST_FIRE: begin
            tile_cnt_d = tile_cnt_q + CNT_W'(1);
            if (tile_start) begin
               state_d = start_join ? ST_FIRE : ST_ARMED;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         mask_q         <= '0;
         to_lim_q       <= '0;
         to_cnt_q       <= '0;
         tile_cnt_q     <= '0;
         join_timeout_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         mask_q         <= mask_d;
         to_lim_q       <= to_lim_d;
         to_cnt_q       <= to_cnt_d;
         tile_cnt_q     <= tile_cnt_d;
         join_timeout_q <= join_timeout_d;
      end
   end

   assign join_done    = (state_q == ST_FIRE);
   assign join_timeout = join_timeout_q;
   assign busy         = armed;
   assign pending      = armed ? (mask_q & ~sticky) : '0;
   assign tile_cnt     = tile_cnt_q;

endmodule

// File: tb/tb_gen_done_join.sv
// Cycle-by-cycle vector bench for gen_done_join (NUM_SRC=3, CNT_W=4):
// each row drives one cycle of inputs and states the outputs seen that cycle.
module tb_gen_done_join;

   localparam int NS = 3;
   localparam int TW = 20;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tile_start = 1'b0;
   logic [NS-1:0] src_mask = '0;
   logic [NS-1:0] src_done = '0;
   logic [TW-1:0] timeout_cyc = '0;
   logic          join_done;
   logic          join_timeout;
   logic [NS-1:0] pending;
   logic          busy;
   logic [CW-1:0] tile_cnt;

   gen_done_join #(.NUM_SRC(NS), .TO_W(TW), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .tile_start  (tile_start),
      .src_mask    (src_mask),
      .src_done    (src_done),
      .timeout_cyc (timeout_cyc),
      .join_done   (join_done),
      .join_timeout(join_timeout),
      .pending     (pending),
      .busy        (busy),
      .tile_cnt    (tile_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          r;
      logic          st;
      logic [NS-1:0] m;
      logic [NS-1:0] d;
      logic [TW-1:0] to;
      logic          jd;
      logic          jt;
      logic [NS-1:0] p;
      logic          b;
      logic [CW-1:0] c;
   } vec_t;

   typedef struct {
      int            idx;
      logic          jd;
      logic          jt;
      logic [NS-1:0] p;
      logic          b;
      logic [CW-1:0] c;
   } exp_t;

   vec_t tbl[$];
   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic add(input logic r, input logic st, input logic [NS-1:0] m,
                      input logic [NS-1:0] d, input int to, input logic jd,
                      input logic jt, input logic [NS-1:0] p, input logic b,
                      input int c);
      vec_t v;
      v.r = r; v.st = st; v.m = m; v.d = d; v.to = TW'(to);
      v.jd = jd; v.jt = jt; v.p = p; v.b = b; v.c = CW'(c);
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input int act, input int req);
      if (act != req) begin
         n_bad++;
         $display("FAIL vec %0d %s: got %0d expected %0d", idx, name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("join_done", e.idx, int'(join_done), int'(e.jd));
         chk("join_timeout", e.idx, int'(join_timeout), int'(e.jt));
         chk("pending", e.idx, int'(pending), int'(e.p));
         chk("busy", e.idx, int'(busy), int'(e.b));
         chk("tile_cnt", e.idx, int'(tile_cnt), int'(e.c));
         chk("pulse_excl", e.idx, int'(join_done & join_timeout), 0);
         $display("vec %0d: jd=%0d jt=%0d pend=%b busy=%0d cnt=%0d", e.idx,
                  join_done, join_timeout, pending, busy, tile_cnt);
      end
   end

   initial begin
      //   r  st m       d       to  jd jt p       b  cnt
      add(1, 0, 3'b000, 3'b000, 0,  0, 0, 3'b000, 0, 0);
      add(0, 0, 3'b000, 3'b000, 0,  0, 0, 3'b000, 0, 0);
      // two sources, last pulse four cycles after the first
      add(0, 1, 3'b011, 3'b000, 0,  0, 0, 3'b000, 0, 0);
      add(0, 0, 3'b000, 3'b000, 0,  0, 0, 3'b011, 1, 0);
      add(0, 0, 3'b000, 3'b000, 0,  0, 0, 3'b011, 1, 0);
      add(0, 0, 3'b000, 3'b001, 0,  0, 0, 3'b011, 1, 0);
      add(0, 0, 3'b000, 3'b000, 0,  0, 0, 3'b010, 1, 0);
      add(0, 0, 3'b000, 3'b000, 0,  0, 0, 3'b010, 1, 0);
      add(0, 0, 3'b000, 3'b000, 0,  0, 0, 3'b010, 1, 0);
      add(0, 0, 3'b000, 3'b010, 0,  0, 0, 3'b010, 1, 0);
      add(0, 0, 3'b000, 3'b000, 0,  1, 0, 3'b000, 0, 0);
      add(0, 0, 3'b000, 3'b000, 0,  0, 0, 3'b000, 0, 1);
      // mask 101: unmasked pulse ignored, two final pulses together
      add(0, 1, 3'b101, 3'b000, 0,  0, 0, 3'b000, 0, 1);
      add(0, 0, 3'b000, 3'b010, 0,  0, 0, 3'b101, 1, 1);
      add(0, 0, 3'b000, 3'b101, 0,  0, 0, 3'b101, 1, 1);
      add(0, 0, 3'b000, 3'b000, 0,  1, 0, 3'b000, 0, 1);
      add(0, 0, 3'b000, 3'b000, 0,  0, 0, 3'b000, 0, 2);
      // timeout of 10 with source 0 never done
      add(0, 1, 3'b001, 3'b000, 10, 0, 0, 3'b000, 0, 2);
      for (int k = 0; k < 10; k++) begin
         add(0, 0, 3'b000, (k == 4) ? 3'b010 : 3'b000, 0, 0, 0, 3'b001, 1, 2);
      end
      add(0, 0, 3'b000, 3'b000, 0,  0, 1, 3'b000, 0, 2);
      add(0, 0, 3'b000, 3'b000, 0,  0, 0, 3'b000, 0, 2);
      // pulse in IDLE discarded; pulse coinciding with start captured
      add(0, 0, 3'b000, 3'b001, 0,  0, 0, 3'b000, 0, 2);
      add(0, 1, 3'b001, 3'b000, 0,  0, 0, 3'b000, 0, 2);
      add(0, 0, 3'b000, 3'b000, 0,  0, 0, 3'b001, 1, 2);
      add(0, 0, 3'b000, 3'b000, 0,  0, 0, 3'b001, 1, 2);
      add(0, 0, 3'b000, 3'b001, 0,  0, 0, 3'b001, 1, 2);
      add(0, 0, 3'b000, 3'b000, 0,  1, 0, 3'b000, 0, 2);
      add(0, 1, 3'b001, 3'b001, 0,  0, 0, 3'b000, 0, 3);
      add(0, 0, 3'b000, 3'b000, 0,  1, 0, 3'b000, 0, 3);
      add(0, 0, 3'b000, 3'b000, 0,  0, 0, 3'b000, 0, 4);
      // reset mid-window with pending=010, later pulse lost
      add(0, 1, 3'b011, 3'b000, 0,  0, 0, 3'b000, 0, 4);
      add(0, 0, 3'b000, 3'b001, 0,  0, 0, 3'b011, 1, 4);
      add(0, 0, 3'b000, 3'b000, 0,  0, 0, 3'b010, 1, 4);
      add(1, 0, 3'b000, 3'b000, 0,  0, 0, 3'b000, 0, 0);
      add(0, 0, 3'b000, 3'b010, 0,  0, 0, 3'b000, 0, 0);
      add(0, 0, 3'b000, 3'b000, 0,  0, 0, 3'b000, 0, 0);
      add(0, 0, 3'b000, 3'b000, 0,  0, 0, 3'b000, 0, 0);
      // restart while armed drops earlier stickies without a pulse
      add(0, 1, 3'b011, 3'b000, 0,  0, 0, 3'b000, 0, 0);
      add(0, 0, 3'b000, 3'b001, 0,  0, 0, 3'b011, 1, 0);
      add(0, 1, 3'b011, 3'b000, 0,  0, 0, 3'b010, 1, 0);
      add(0, 0, 3'b000, 3'b010, 0,  0, 0, 3'b011, 1, 0);
      add(0, 0, 3'b000, 3'b000, 0,  0, 0, 3'b001, 1, 0);
      add(0, 0, 3'b000, 3'b001, 0,  0, 0, 3'b001, 1, 0);
      add(0, 0, 3'b000, 3'b000, 0,  1, 0, 3'b000, 0, 0);
      add(0, 0, 3'b000, 3'b000, 0,  0, 0, 3'b000, 0, 1);
      // join and timeout in the same cycle, then start during FIRE
      add(0, 1, 3'b001, 3'b000, 3,  0, 0, 3'b000, 0, 1);
      add(0, 0, 3'b000, 3'b000, 0,  0, 0, 3'b001, 1, 1);
      add(0, 0, 3'b000, 3'b000, 0,  0, 0, 3'b001, 1, 1);
      add(0, 0, 3'b000, 3'b001, 0,  0, 0, 3'b001, 1, 1);
      add(0, 1, 3'b010, 3'b000, 0,  1, 0, 3'b000, 0, 1);
      add(0, 0, 3'b000, 3'b000, 0,  0, 0, 3'b010, 1, 2);
      add(0, 0, 3'b000, 3'b010, 0,  0, 0, 3'b010, 1, 2);
      add(0, 0, 3'b000, 3'b000, 0,  1, 0, 3'b000, 0, 2);
      // empty-mask joins until the 4-bit counter wraps past 16 to 1
      for (int k = 0; k < 14; k++) begin
         add(0, 1, 3'b000, 3'b000, 0, 0, 0, 3'b000, 0, (3 + k) % 16);
         add(0, 0, 3'b000, 3'b000, 0, 1, 0, 3'b000, 0, (3 + k) % 16);
      end
      add(0, 0, 3'b000, 3'b000, 0,  0, 0, 3'b000, 0, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         exp_t e;
         @(posedge clk);
         #1;
         rst         = tbl[i].r;
         tile_start  = tbl[i].st;
         src_mask    = tbl[i].m;
         src_done    = tbl[i].d;
         timeout_cyc = tbl[i].to;
         e.idx = i; e.jd = tbl[i].jd; e.jt = tbl[i].jt;
         e.p = tbl[i].p; e.b = tbl[i].b; e.c = tbl[i].c;
         exp_q.push_back(e);
         n_vec++;
      end
      @(posedge clk);
      #1;
      tile_start = 1'b0;
      src_done   = '0;
      for (int w = 0; w < 5 && exp_q.size() != 0; w++) begin
         @(posedge clk);
      end
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d unchecked expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
